// File: rtl/spi_reg_access_if.sv
// Request/response and SPI-master signal bundle for spi_reg_access.
// Handshake: a request transfers on a clock edge where req_valid & req_ready are both high; rsp_valid is a one-cycle pulse with no backpressure.
interface spi_reg_access_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [DATA_WIDTH-2:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  spi_cs_n;
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_data_out;
  logic                  spi_finish;
  logic [DATA_WIDTH-1:0] spi_data_in;

  // Environment side: the requester plus the SPI master core.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, spi_finish, spi_data_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, spi_cs_n, spi_start, spi_data_out
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, spi_finish, spi_data_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, spi_cs_n, spi_start, spi_data_out
  );
endinterface

// File: rtl/spi_reg_access.sv
// Frames one register read/write as a two-byte SPI transaction ({rw, addr} then data/dummy)
// around an SPI master core, with per-byte finish timeout and a single-cycle response.
module spi_reg_access #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_access_if.slave       bus,
  output logic [2:0]            dbg_state
);
  localparam int AW      = DATA_WIDTH - 1;
  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX = (TIMEOUT > MAX_SH) ? TIMEOUT : MAX_SH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_CMD       = 3'd2;
  localparam logic [2:0] S_WAIT_CMD  = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_WAIT_DATA = 3'd5;
  localparam logic [2:0] S_HOLD      = 3'd6;
  localparam logic [2:0] S_RESP      = 3'd7;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [CW-1:0]         cnt;
  logic                  finish_d;
  logic                  fin_edge;
  logic                  in_wait;
  logic                  timeout_hit;
  logic                  wr_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] cmd_byte;
  logic [DATA_WIDTH-1:0] second_byte;

  assign fin_edge    = bus.spi_finish & ~finish_d;
  assign in_wait     = (state == S_WAIT_CMD) || (state == S_WAIT_DATA);
  // A finish edge in the expiry cycle wins, so no error is flagged then.
  assign timeout_hit = in_wait && !fin_edge && (cnt == TO_LAST);
  assign cmd_byte    = {~wr_q, addr_q};
  assign second_byte = wr_q ? wdata_q : '0;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.req_valid) state_nxt = S_SETUP;
      S_SETUP:     if (cnt == SETUP_LAST) state_nxt = S_CMD;
      S_CMD:       state_nxt = S_WAIT_CMD;
      S_WAIT_CMD:  if (fin_edge) state_nxt = S_DATA;
                   else if (timeout_hit) state_nxt = S_HOLD;
      S_DATA:      state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (fin_edge || timeout_hit) state_nxt = S_HOLD;
      S_HOLD:      if (cnt == HOLD_LAST) state_nxt = S_RESP;
      S_RESP:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      finish_d         <= 1'b0;
      wr_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      rdata_q          <= '0;
      err_q            <= 1'b0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_err      <= 1'b0;
      bus.spi_cs_n     <= 1'b1;
      bus.spi_start    <= 1'b0;
      bus.spi_data_out <= '0;
    end else begin
      state    <= state_nxt;
      finish_d <= bus.spi_finish;

      // One counter serves setup, hold and timeout; it restarts on every state change.
      if ((state_nxt != state) || (state == S_IDLE)) cnt <= '0;
      else                                           cnt <= cnt + 1'b1;

      if (state == S_IDLE && state_nxt == S_SETUP) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= 1'b0;
      end
      if (timeout_hit) err_q <= 1'b1;
      if (state == S_WAIT_DATA && fin_edge) rdata_q <= bus.spi_data_in;

      bus.req_ready <= (state_nxt == S_IDLE);
      bus.spi_cs_n  <= (state_nxt == S_IDLE) || (state_nxt == S_RESP);
      bus.spi_start <= (state_nxt == S_CMD) || (state_nxt == S_DATA);
      bus.rsp_valid <= (state_nxt == S_RESP);
      bus.rsp_err   <= (state_nxt == S_RESP) && err_q;
      bus.rsp_rdata <= ((state_nxt == S_RESP) && !err_q && !wr_q) ? rdata_q : '0;

      if (state_nxt == S_CMD || state_nxt == S_WAIT_CMD)
        bus.spi_data_out <= cmd_byte;
      else if (state_nxt == S_DATA || state_nxt == S_WAIT_DATA)
        bus.spi_data_out <= second_byte;
      else
        bus.spi_data_out <= '0;
    end
  end
endmodule

// File: tb/tb_spi_reg_access.sv
// Directed bench for spi_reg_access: a behavioural SPI slave answers start pulses, a negedge
// monitor records frame timing, and a response scoreboard checks {err, rdata} in order.
module tb_spi_reg_access;
  localparam int DW       = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 16;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  spi_reg_access_if #(.DATA_WIDTH(DW)) bus ();

  spi_reg_access #(
    .DATA_WIDTH(DW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / counters ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- slave model controls ----------------
  logic          slave_en    = 1'b1;
  logic          drop_second = 1'b0;
  int            rd_mode     = 0;
  logic [DW-1:0] rd_val      = '0;
  int            resp_dly    = 2;
  int            fin_len     = 1;
  logic [DW-1:0] pend_q[$];

  // ---------------- monitor state ----------------
  int            acc_cnt = 0;
  int            acc_cyc = 0;
  int            rsp_cnt = 0;
  int            rsp_cyc = -10;
  logic          rsp_cs_n = 1'b0;
  logic          ready_after = 1'b0;
  int            cs_falls = 0;
  int            cs_fall_cyc = 0;
  int            ready_bad = 0;
  int            byte_idx = 0;
  logic          cs_prev = 1'b1;
  logic          fin_prev = 1'b0;
  logic [DW-1:0] last_cmd = '0;
  int            start_cycs[$];
  int            fedge_cycs[$];
  logic [DW-1:0] tx_q[$];

  initial begin
    logic [DW-1:0] rb;
    logic [DW:0]   e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.spi_cs_n) byte_idx = 0;
        if (bus.req_valid && bus.req_ready) begin
          acc_cnt++;
          acc_cyc  = cyc;
          cs_falls = 0;
          start_cycs.delete();
          fedge_cycs.delete();
          tx_q.delete();
        end
        if (!bus.spi_cs_n && cs_prev) begin
          cs_falls++;
          cs_fall_cyc = cyc;
        end
        if (!bus.spi_cs_n && bus.req_ready) ready_bad++;
        if (bus.spi_start) begin
          start_cycs.push_back(cyc);
          tx_q.push_back(bus.spi_data_out);
          if (byte_idx == 0) begin
            last_cmd = bus.spi_data_out;
            rb = bus.spi_data_out;
          end else begin
            case (rd_mode)
              0:       rb = bus.spi_data_out;
              1:       rb = rd_val;
              default: rb = last_cmd ^ 8'h3C;
            endcase
          end
          if (slave_en && !(drop_second && byte_idx != 0)) pend_q.push_back(rb);
          byte_idx++;
        end
        if (bus.spi_finish && !fin_prev) fedge_cycs.push_back(cyc);
        if (bus.rsp_valid) begin
          rsp_cnt++;
          rsp_cyc  = cyc;
          rsp_cs_n = bus.spi_cs_n;
          if (exp_q.size() == 0) check_eq("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check_eq("rsp_err_rdata", {23'd0, bus.rsp_err, bus.rsp_rdata}, {23'd0, e});
          end
        end
        if (cyc == rsp_cyc + 1) ready_after = bus.req_ready;
      end
      cs_prev  = bus.spi_cs_n;
      fin_prev = bus.spi_finish;
    end
  end

  // Slave responder: raises finish resp_dly cycles after a start, held fin_len cycles.
  initial begin
    logic [DW-1:0] b;
    bus.spi_finish  = 1'b0;
    bus.spi_data_in = '0;
    forever begin
      @(posedge clk); #1;
      if (pend_q.size() > 0) begin
        b = pend_q.pop_front();
        repeat (resp_dly - 1) @(posedge clk);
        #1;
        bus.spi_data_in = b;
        bus.spi_finish  = 1'b1;
        repeat (fin_len) @(posedge clk);
        #1;
        bus.spi_finish  = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_accept(input logic wr, input logic [DW-2:0] addr, input logic [DW-1:0] wdata);
    int waited;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) check_eq("accept_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    // Scramble fields after acceptance; the DUT must have registered them.
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom_range(0, 1));
    bus.req_addr  = 7'($urandom_range(0, 127));
    bus.req_wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_rsp(input int target);
    int waited;
    waited = 0;
    while (rsp_cnt < target && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    if (rsp_cnt < target) check_eq("rsp_wait", 32'(rsp_cnt), 32'(target));
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic wr, input logic [DW-2:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW:0] exp_rsp);
    int n0;
    n0 = rsp_cnt;
    ready_after = 1'b0;
    exp_q.push_back(exp_rsp);
    drive_accept(wr, addr, wdata);
    wait_rsp(n0 + 1);
  endtask

  task automatic check_frame(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    check_eq("cs_fall_count", 32'(cs_falls), 32'd1);
    check_eq("cs_fall_cycle", 32'(cs_fall_cyc - acc_cyc), 32'd1);
    check_eq("start_count", 32'(start_cycs.size()), 32'd2);
    check_eq("finish_edges", 32'(fedge_cycs.size()), 32'd2);
    if (start_cycs.size() == 2 && fedge_cycs.size() == 2) begin
      check_eq("start0_cycle", 32'(start_cycs[0] - acc_cyc), 32'(CS_SETUP + 1));
      check_eq("start1_cycle", 32'(start_cycs[1] - fedge_cycs[0]), 32'd1);
      check_eq("tx_cmd", {24'd0, tx_q[0]}, {24'd0, b0});
      check_eq("tx_data", {24'd0, tx_q[1]}, {24'd0, b1});
      check_eq("rsp_cycle", 32'(rsp_cyc - fedge_cycs[1]), 32'(CS_HOLD + 1));
    end
    check_eq("rsp_cs_n_high", {31'd0, rsp_cs_n}, 32'd1);
    check_eq("ready_after_rsp", {31'd0, ready_after}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  logic          b2b_wr[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [DW-2:0] b2b_addr[4]  = '{7'h01, 7'h02, 7'h03, 7'h7F};
  logic [DW-1:0] b2b_wdata[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int n0;
    int a0;
    int waited;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("rst_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check_eq("rst_start", {31'd0, bus.spi_start}, 32'd0);
    check_eq("rst_data_out", {24'd0, bus.spi_data_out}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check_eq("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write with loopback slave.
    do_req(1'b1, 7'h15, 8'hA5, 9'h000);
    check_frame(8'h15, 8'hA5);

    // Read, slave returns 0x5C on the second byte.
    rd_mode = 1;
    rd_val  = 8'h5C;
    do_req(1'b0, 7'h2A, 8'hFF, 9'h05C);
    check_frame(8'hAA, 8'h00);

    // Multi-cycle finish: one advance per rising edge only.
    fin_len = 3;
    do_req(1'b1, 7'h15, 8'hA5, 9'h000);
    check_frame(8'h15, 8'hA5);
    do_req(1'b0, 7'h2A, 8'h00, 9'h05C);
    check_frame(8'hAA, 8'h00);
    fin_len = 1;

    // Finish never arrives: timeout error response.
    slave_en = 1'b0;
    do_req(1'b0, 7'h33, 8'h00, 9'h100);
    check_eq("to_start_count", 32'(start_cycs.size()), 32'd1);
    check_eq("to_cs_fall_count", 32'(cs_falls), 32'd1);
    check_eq("to_rsp_cycle", 32'(rsp_cyc - acc_cyc), 32'(1 + CS_SETUP + 1 + TIMEOUT + CS_HOLD + 1));
    check_eq("to_rsp_cs_n_high", {31'd0, rsp_cs_n}, 32'd1);
    check_eq("to_ready_after", {31'd0, ready_after}, 32'd1);
    slave_en = 1'b1;
    do_req(1'b0, 7'h2A, 8'h00, 9'h05C);
    check_frame(8'hAA, 8'h00);

    // Four requests with req_valid held high throughout.
    rd_mode   = 2;
    ready_bad = 0;
    n0        = rsp_cnt;
    a0        = acc_cnt;
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h0BE);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h0C3);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_wr    = b2b_wr[i];
      bus.req_addr  = b2b_addr[i];
      bus.req_wdata = b2b_wdata[i];
      waited = 0;
      while (!bus.req_ready && waited < 200) begin
        @(posedge clk); #1;
        waited++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    wait_rsp(n0 + 4);
    check_eq("b2b_accepts", 32'(acc_cnt - a0), 32'd4);
    check_eq("b2b_responses", 32'(rsp_cnt - n0), 32'd4);
    check_eq("b2b_ready_low_in_txn", 32'(ready_bad), 32'd0);
    check_eq("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while waiting for the data-byte finish.
    rd_mode     = 0;
    drop_second = 1'b1;
    drive_accept(1'b1, 7'h44, 8'hC3);
    waited = 0;
    while (dbg_state != 3'd5 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("reach_wait_data", {29'd0, dbg_state}, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    n0    = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("arst_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check_eq("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("arst_data_out", {24'd0, bus.spi_data_out}, 32'd0);
    check_eq("arst_state", {29'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    pend_q.delete();
    drop_second = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    do_req(1'b1, 7'h44, 8'hC3, 9'h000);
    check_frame(8'h44, 8'hC3);

    repeat (5) @(posedge clk);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
